// File: rtl/switch_pulse_sequencer_if.sv
// Control and status bundle for the A/B photonic switch pulse sequencer.
// The master side supplies timing and handshake; the slave side reports switch drive and status.
interface switch_pulse_sequencer_if #(
    parameter int CW = 16,
    parameter int NW = 8
);
    logic          en;
    logic          en_1MHz;
    logic          start;
    logic          abort;
    logic [CW-1:0] t_a;
    logic [CW-1:0] t_b;
    logic [CW-1:0] t_dead;
    logic [NW-1:0] n_cycles;
    logic          sw_a;
    logic          sw_b;
    logic          busy;
    logic          done;
    logic [NW-1:0] cycle_cnt;
    logic [2:0]    state;

    modport master (
        output en, en_1MHz, start, abort, t_a, t_b, t_dead, n_cycles,
        input  sw_a, sw_b, busy, done, cycle_cnt, state
    );

    modport slave (
        input  en, en_1MHz, start, abort, t_a, t_b, t_dead, n_cycles,
        output sw_a, sw_b, busy, done, cycle_cnt, state
    );
endinterface

// File: rtl/switch_pulse_sequencer.sv
// Break-before-make A/B switch sequencer: dead, ON_A, dead, ON_B repeated n_cycles times,
// with every phase timed in 1 MHz ticks.
module switch_pulse_sequencer #(
    parameter int CW = 16,
    parameter int NW = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    switch_pulse_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEAD1 = 3'd1,
        ON_A  = 3'd2,
        DEAD2 = 3'd3,
        ON_B  = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] cyc_q, cyc_d;
    logic [CW-1:0] ta_q, tb_q, td_q;
    logic [NW-1:0] n_q;
    logic          latch;
    logic          tick;
    logic          phase_end;
    logic [CW-1:0] len;
    logic [CW-1:0] len_last;
    logic [NW-1:0] cyc_inc;

    assign tick    = bus.en && bus.en_1MHz;
    assign cyc_inc = cyc_q + NW'(1);

    // A programmed length of 0 behaves as 1, so the last count is 0 in both cases.
    always_comb begin
        len = '0;
        case (state_q)
            DEAD1, DEAD2: len = td_q;
            ON_A:         len = ta_q;
            ON_B:         len = tb_q;
            default:      len = '0;
        endcase
        len_last  = (len == '0) ? '0 : len - CW'(1);
        phase_end = (cnt_q == len_last);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        latch   = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        latch   = 1'b1;
                        state_d = DEAD1;
                        cnt_d   = '0;
                        cyc_d   = '0;
                    end
                end
                DEAD1, ON_A, DEAD2, ON_B: begin
                    if (tick) begin
                        if (phase_end) begin
                            cnt_d = '0;
                            case (state_q)
                                DEAD1:   state_d = ON_A;
                                ON_A:    state_d = DEAD2;
                                DEAD2:   state_d = ON_B;
                                default: begin
                                    cyc_d   = cyc_inc;
                                    state_d = ((n_q != '0) && (cyc_inc == n_q)) ? FIN : DEAD1;
                                end
                            endcase
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                FIN:     state_d = IDLE;
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cyc_q    <= '0;
            ta_q     <= '0;
            tb_q     <= '0;
            td_q     <= '0;
            n_q      <= '0;
            bus.sw_a <= 1'b0;
            bus.sw_b <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cyc_q    <= cyc_d;
            if (latch) begin
                ta_q <= bus.t_a;
                tb_q <= bus.t_b;
                td_q <= bus.t_dead;
                n_q  <= bus.n_cycles;
            end
            bus.sw_a <= (state_d == ON_A);
            bus.sw_b <= (state_d == ON_B);
            bus.busy <= (state_d != IDLE);
            bus.done <= (state_d == FIN);
        end
    end

    assign bus.cycle_cnt = cyc_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_switch_pulse_sequencer.sv
// Directed-vector bench for switch_pulse_sequencer: table-driven full runs plus
// hand-written reset, abort, enable-freeze and randomised invariant sequences.
module tb_switch_pulse_sequencer;

    localparam int CW = 16;
    localparam int NW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   done_pulses = 0;

    always #5 clk = ~clk;

    switch_pulse_sequencer_if #(.CW(CW), .NW(NW)) bus ();

    switch_pulse_sequencer #(.CW(CW), .NW(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int ta;
        int tb;
        int td;
        int n;
        int exp_a;
        int exp_b;
        int exp_busy;
        int exp_cnt;
    } vec_t;

    vec_t vecs[4];

    always @(negedge clk) if (bus.done === 1'b1) done_pulses++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_params(input int ta, input int tb, input int td, input int n);
        bus.t_a      = CW'(ta);
        bus.t_b      = CW'(tb);
        bus.t_dead   = CW'(td);
        bus.n_cycles = NW'(n);
    endtask

    // Start a run with a tick on every clock and tally each output over its busy window.
    task automatic run_vec(input int idx, input vec_t v);
        int  a_cnt = 0;
        int  b_cnt = 0;
        int  busy_cnt = 0;
        int  ov = 0;
        int  d0;
        bit  timed_out = 1'b1;
        d0 = done_pulses;
        @(negedge clk);
        set_params(v.ta, v.tb, v.td, v.n);
        bus.start = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (!bus.busy) begin
                timed_out = 1'b0;
                break;
            end
            busy_cnt++;
            if (bus.sw_a) a_cnt++;
            if (bus.sw_b) b_cnt++;
            if (bus.sw_a && bus.sw_b) ov++;
        end
        check($sformatf("vec%0d_timeout", idx), timed_out, 0);
        check($sformatf("vec%0d_sw_a_clks", idx), a_cnt, v.exp_a);
        check($sformatf("vec%0d_sw_b_clks", idx), b_cnt, v.exp_b);
        check($sformatf("vec%0d_busy_clks", idx), busy_cnt, v.exp_busy);
        check($sformatf("vec%0d_overlap", idx), ov, 0);
        check($sformatf("vec%0d_cycle_cnt", idx), bus.cycle_cnt, v.exp_cnt);
        check($sformatf("vec%0d_state_idle", idx), bus.state, 0);
        @(negedge clk);
        check($sformatf("vec%0d_done_pulses", idx), done_pulses - d0, 1);
    endtask

    initial begin
        int  d0;
        int  cnt;
        bit  seen;

        // t_a, t_b, t_dead, n | sw_a clks, sw_b clks, busy clks (incl. FIN), cycle_cnt
        vecs[0] = '{3, 4, 2, 2, 6, 8, 23, 2};
        vecs[1] = '{0, 0, 0, 1, 1, 1, 5, 1};
        vecs[2] = '{1, 2, 1, 3, 3, 6, 16, 3};
        vecs[3] = '{5, 1, 0, 1, 5, 1, 9, 1};

        bus.en = 1'b1;
        bus.en_1MHz = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_params(0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("rst_state", bus.state, 0);
        check("rst_sw_a", bus.sw_a, 0);
        check("rst_sw_b", bus.sw_b, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_cycle_cnt", bus.cycle_cnt, 0);
        reset = 1'b1;
        bus.en_1MHz = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

        // start and abort together in IDLE leave the sequencer idle
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_state", bus.state, 0);
        check("start_abort_busy", bus.busy, 0);

        // asynchronous reset while ON_A in the second cycle
        set_params(3, 4, 2, 2);
        bus.start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.sw_a && bus.cycle_cnt == 1) begin
                seen = 1'b1;
                break;
            end
        end
        check("mid_reset_reach_on_a", seen, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_reset_sw_a", bus.sw_a, 0);
        check("mid_reset_busy", bus.busy, 0);
        check("mid_reset_cycle_cnt", bus.cycle_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle", bus.state, 0);
        check("post_reset_busy", bus.busy, 0);

        // free-running run aborted once five cycles have completed
        d0 = done_pulses;
        set_params(1, 1, 1, 0);
        bus.start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.cycle_cnt == 5) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_reach_5", seen, 1);
        check("abort_busy_before", bus.busy, 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_state", bus.state, 0);
        check("abort_sw_a", bus.sw_a, 0);
        check("abort_sw_b", bus.sw_b, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_cycle_cnt", bus.cycle_cnt, 5);
        @(negedge clk);
        check("abort_no_done", done_pulses - d0, 0);

        // en low for 10 ticks inside ON_B, with an ignored start during the freeze
        set_params(2, 4, 1, 1);
        bus.start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.sw_b) begin
                seen = 1'b1;
                break;
            end
        end
        check("freeze_reach_on_b", seen, 1);
        cnt = 1;
        bus.en = 1'b0;
        set_params(7, 50, 9, 5);
        bus.start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.sw_b) cnt++;
        end
        bus.en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.sw_b) break;
            cnt++;
        end
        check("freeze_sw_b_clks", cnt, 14);
        check("freeze_cycle_cnt", bus.cycle_cnt, 1);
        @(negedge clk);
        check("freeze_ignored_start_busy", bus.busy, 0);
        check("freeze_ignored_start_state", bus.state, 0);

        // random ticks, enables, starts and aborts with invariant checks
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            check("rand_overlap", bus.sw_a & bus.sw_b, 0);
            check("rand_done_fin", bus.done, (bus.state == 3'd5));
            check("rand_busy_state", bus.busy, (bus.state != 3'd0));
            bus.en      = ($urandom_range(7) != 0);
            bus.en_1MHz = ($urandom_range(3) == 0);
            bus.start   = ($urandom_range(15) == 0);
            bus.abort   = ($urandom_range(63) == 0);
            set_params($urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
